// File: rtl/jump_sequencer_if.sv
// Player-jump control bus: button, permission and frame-tick inputs plus the
// motion/status outputs of the jump sequencer.
interface jump_sequencer_if;
  logic        can_jump;
  logic        jump_btn;
  logic        frame_tick;
  logic [9:0]  y_offset;
  logic        airborne;
  logic        jump_ack;
  logic [2:0]  state;
  logic [15:0] jump_count;

  modport master (
    output can_jump, jump_btn, frame_tick,
    input  y_offset, airborne, jump_ack, state, jump_count
  );

  modport slave (
    input  can_jump, jump_btn, frame_tick,
    output y_offset, airborne, jump_ack, state, jump_count
  );
endinterface

// File: rtl/jump_sequencer.sv
// Jump sequencer: synchronizes and debounces the jump button, then walks the
// player height through rise / apex / fall / cooldown on frame ticks.
module jump_sequencer #(
  parameter int RISE_STEPS  = 8,
  parameter int APEX_HOLD   = 4,
  parameter int COOLDOWN    = 6,
  parameter int STEP_HEIGHT = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic             proc_clk,
  input  logic             reset,
  jump_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_GROUND = 3'd0,
    S_RISE   = 3'd1,
    S_APEX   = 3'd2,
    S_FALL   = 3'd3,
    S_COOL   = 3'd4
  } state_t;

  localparam int MAXP_RA = (RISE_STEPS > APEX_HOLD) ? RISE_STEPS : APEX_HOLD;
  localparam int MAXP    = (MAXP_RA > COOLDOWN) ? MAXP_RA : COOLDOWN;
  localparam int TW      = $clog2(MAXP + 1);
  localparam int DW      = $clog2(DEBOUNCE + 1);
  localparam logic [9:0] STEP = 10'(STEP_HEIGHT);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_db_cnt;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_pending;
  state_t        r_state;
  logic [9:0]    r_y;
  logic [TW-1:0] r_tick;
  logic          r_ack;
  logic [15:0]   r_count;
  logic          w_rise;
  logic          w_accept;

  // Debounce counter saturates at DEBOUNCE; any low sample restarts it.
  always_ff @(posedge proc_clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_db_cnt   <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], bus.jump_btn};
      r_stable_d <= r_stable;
      if (!r_sync[1]) begin
        r_db_cnt <= '0;
        r_stable <= 1'b0;
      end else if (r_db_cnt != DW'(DEBOUNCE)) begin
        r_db_cnt <= r_db_cnt + 1'b1;
        r_stable <= (r_db_cnt == DW'(DEBOUNCE - 1));
      end
    end
  end

  assign w_rise   = r_stable & ~r_stable_d;
  assign w_accept = (r_state == S_GROUND) & r_pending & bus.can_jump;

  // Presses are only latched on the ground; presses while moving are dropped.
  always_ff @(posedge proc_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_GROUND;
      r_y       <= '0;
      r_tick    <= '0;
      r_ack     <= 1'b0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_GROUND: begin
          r_y <= '0;
          if (w_accept) begin
            r_state   <= S_RISE;
            r_tick    <= '0;
            r_ack     <= 1'b1;
            r_pending <= 1'b0;
            if (r_count != '1) r_count <= r_count + 16'd1;
          end else if (w_rise) begin
            r_pending <= 1'b1;
          end
        end
        S_RISE: if (bus.frame_tick) begin
          r_y <= r_y + STEP;
          if (r_tick == TW'(RISE_STEPS - 1)) begin
            r_state <= S_APEX;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_APEX: if (bus.frame_tick) begin
          if (r_tick == TW'(APEX_HOLD - 1)) begin
            r_state <= S_FALL;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_FALL: if (bus.frame_tick) begin
          if (r_y <= STEP) begin
            r_y     <= '0;
            r_state <= S_COOL;
            r_tick  <= '0;
          end else begin
            r_y    <= r_y - STEP;
            r_tick <= r_tick + 1'b1;
          end
        end
        S_COOL: begin
          r_y <= '0;
          if (bus.frame_tick) begin
            if (r_tick == TW'(COOLDOWN - 1)) begin
              r_state <= S_GROUND;
              r_tick  <= '0;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_GROUND;
          r_y       <= '0;
          r_tick    <= '0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y_offset   = r_y;
  assign bus.state      = r_state;
  assign bus.airborne   = (r_state == S_RISE) || (r_state == S_APEX) || (r_state == S_FALL);
  assign bus.jump_ack   = r_ack;
  assign bus.jump_count = r_count;

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: directed table + hand sequences, then random
// stimulus against a jump-progress reference model.
module tb_jump_sequencer;
  localparam int RISE_STEPS  = 8;
  localparam int APEX_HOLD   = 4;
  localparam int COOLDOWN    = 6;
  localparam int STEP_HEIGHT = 4;
  localparam int DEBOUNCE    = 3;
  localparam int TOTAL       = 2 * RISE_STEPS + APEX_HOLD + COOLDOWN;
  localparam int HW          = DEBOUNCE + 3;

  if (RISE_STEPS * STEP_HEIGHT > 1023) begin : g_bad_params
    initial begin
      $display("FAIL params: peak height %0d exceeds 1023", RISE_STEPS * STEP_HEIGHT);
      $fatal(1, "bad parameters");
    end
  end

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ack = 0;
  bit   cmp_en = 0;

  jump_sequencer_if bus ();

  jump_sequencer #(
    .RISE_STEPS(RISE_STEPS), .APEX_HOLD(APEX_HOLD), .COOLDOWN(COOLDOWN),
    .STEP_HEIGHT(STEP_HEIGHT), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .proc_clk(clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.jump_ack === 1'b1) n_ack <= n_ack + 1;
  end

  // Reference: button history window for debounce, jump tracked as a count
  // of motion ticks since acceptance; height and phase follow arithmetically.
  logic [HW-1:0] m_hist;
  logic m_pend, m_jump, m_ack;
  int   m_k, m_cnt;

  function automatic bit m_rise(input logic [HW-1:0] h);
    return (&h[DEBOUNCE+1:2]) && !(&h[DEBOUNCE+2:3]);
  endfunction

  function automatic int exp_state(input logic jmp, input int k);
    if (!jmp) return 0;
    if (k < RISE_STEPS) return 1;
    if (k < RISE_STEPS + APEX_HOLD) return 2;
    if (k < 2 * RISE_STEPS + APEX_HOLD) return 3;
    return 4;
  endfunction

  function automatic int exp_y(input logic jmp, input int k);
    if (!jmp) return 0;
    if (k < RISE_STEPS) return k * STEP_HEIGHT;
    if (k < RISE_STEPS + APEX_HOLD) return RISE_STEPS * STEP_HEIGHT;
    if (k < 2 * RISE_STEPS + APEX_HOLD) return (2 * RISE_STEPS + APEX_HOLD - k) * STEP_HEIGHT;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist <= '0; m_pend <= 1'b0; m_jump <= 1'b0; m_ack <= 1'b0;
      m_k <= 0; m_cnt <= 0;
    end else begin
      m_ack  <= 1'b0;
      m_hist <= {m_hist[HW-2:0], bus.jump_btn};
      if (!m_jump) begin
        if (m_pend && bus.can_jump) begin
          m_jump <= 1'b1; m_k <= 0; m_ack <= 1'b1; m_pend <= 1'b0;
          m_cnt  <= (m_cnt == 65535) ? 65535 : m_cnt + 1;
        end else if (m_rise(m_hist)) begin
          m_pend <= 1'b1;
        end
      end else if (bus.frame_tick) begin
        if (m_k + 1 == TOTAL) begin
          m_jump <= 1'b0; m_k <= 0;
        end else begin
          m_k <= m_k + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".y"},     32'(bus.y_offset),   0);
    chk({tag, ".state"}, 32'(bus.state),      0);
    chk({tag, ".air"},   32'(bus.airborne),   0);
    chk({tag, ".ack"},   32'(bus.jump_ack),   0);
    chk({tag, ".count"}, 32'(bus.jump_count), 0);
  endtask

  task automatic wait_ack(output int n, output bit got);
    n = 0; got = 0;
    while (!got && n < 30) begin
      step(); n++;
      if (bus.jump_ack === 1'b1) got = 1;
    end
  endtask

  typedef struct {
    logic btn;
    logic can;
    int   ticks;
    int   st;
    int   y;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  n, a0;
    bit  got;
    tbl[0] = '{1'b1, 1'b1, 1, 1, 4};
    tbl[1] = '{1'b1, 1'b1, 6, 1, 28};
    tbl[2] = '{1'b1, 1'b1, 1, 2, 32};
    tbl[3] = '{1'b1, 1'b1, 3, 2, 32};
    tbl[4] = '{1'b1, 1'b1, 1, 3, 32};
    tbl[5] = '{1'b0, 1'b1, 1, 3, 28};
    tbl[6] = '{1'b1, 1'b1, 6, 3, 4};
    tbl[7] = '{1'b1, 1'b1, 1, 4, 0};
    tbl[8] = '{1'b1, 1'b1, 5, 4, 0};
    tbl[9] = '{1'b1, 1'b1, 1, 0, 0};

    reset = 1'b1;
    bus.jump_btn = 1'b0; bus.can_jump = 1'b0; bus.frame_tick = 1'b0;
    repeat (2) step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Short press below debounce length
    repeat (3) step();
    bus.jump_btn = 1'b1; bus.can_jump = 1'b1;
    repeat (2) step();
    bus.jump_btn = 1'b0;
    a0 = n_ack;
    repeat (15) step();
    chk("short_press.acks", 32'(n_ack - a0), 0);
    chk("short_press.state", 32'(bus.state), 0);

    // Full jump with button held
    a0 = n_ack;
    bus.jump_btn = 1'b1;
    wait_ack(n, got);
    chk("accept.seen", 32'(got), 1);
    chk("accept.state", 32'(bus.state), 1);
    chk("accept.y", 32'(bus.y_offset), 0);
    step();
    chk("accept.ack_once", 32'(bus.jump_ack), 0);
    for (int i = 0; i < 10; i++) begin
      bus.jump_btn = tbl[i].btn; bus.can_jump = tbl[i].can;
      bus.frame_tick = 1'b1;
      repeat (tbl[i].ticks) step();
      bus.frame_tick = 1'b0;
      chk($sformatf("tbl%0d.state", i), 32'(bus.state), tbl[i].st);
      chk($sformatf("tbl%0d.y", i), 32'(bus.y_offset), tbl[i].y);
      chk($sformatf("tbl%0d.air", i), 32'(bus.airborne), (tbl[i].st >= 1 && tbl[i].st <= 3) ? 1 : 0);
    end
    repeat (15) step();
    chk("jump.acks", 32'(n_ack - a0), 1);
    chk("jump.count", 32'(bus.jump_count), 1);
    chk("jump.state", 32'(bus.state), 0);

    // Pending press held off by can_jump
    bus.jump_btn = 1'b0; bus.can_jump = 1'b0;
    repeat (6) step();
    bus.jump_btn = 1'b1;
    a0 = n_ack;
    repeat (20) step();
    chk("hold.acks", 32'(n_ack - a0), 0);
    chk("hold.state", 32'(bus.state), 0);
    bus.can_jump = 1'b1;
    step();
    chk("hold.ack", 32'(bus.jump_ack), 1);
    chk("hold.rise", 32'(bus.state), 1);
    step();
    chk("hold.ack_off", 32'(bus.jump_ack), 0);
    chk("hold.count", 32'(bus.jump_count), 2);

    // Async reset mid-rise
    bus.frame_tick = 1'b1;
    repeat (3) step();
    bus.frame_tick = 1'b0;
    chk("midrise.y", 32'(bus.y_offset), 12);
    chk("midrise.state", 32'(bus.state), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    step();
    reset = 1'b0;
    wait_ack(n, got);
    chk("post_reset.accept", 32'(got), 1);
    chk("post_reset.min_latency", 32'((n >= 2 + DEBOUNCE) ? 1 : 0), 1);

    // Random stimulus against the model
    bus.frame_tick = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmp_en = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (cmp_en) begin
        chk("rnd.y",     32'(bus.y_offset),   32'(exp_y(m_jump, m_k)));
        chk("rnd.state", 32'(bus.state),      32'(exp_state(m_jump, m_k)));
        chk("rnd.air",   32'(bus.airborne),   (exp_state(m_jump, m_k) inside {1, 2, 3}) ? 1 : 0);
        chk("rnd.ack",   32'(bus.jump_ack),   32'(m_ack));
        chk("rnd.count", 32'(bus.jump_count), 32'(m_cnt));
      end
      if ($urandom_range(0, 7) == 0) bus.jump_btn = ~bus.jump_btn;
      if ($urandom_range(0, 9) == 0) bus.can_jump = ~bus.can_jump;
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
